traffic_controller_rr: RTL and testbench

//  Parametrised N-approach intersection controller: next-generation traffic FSM.

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/tl_rr_pick.sv | 33 +++
 rtl/traffic_controller_rr.sv | 176 +++++++++++++++++
 tb/tb_traffic_controller_rr.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encoding and lamp codes for the round-robin intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_ALLRED = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_EMG    = 3'd3,
    S_FLASH  = 3'd4
  } phase_e;

  // Per-approach lamp code, ordered {r,y,g}
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  function automatic logic [2:0] flash_code(input logic lit);
    return lit ? L_YEL : L_OFF;
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin search: first pending approach after base, wrapping modulo N_DIR.
module tl_rr_pick #(
  parameter int N_DIR = 4,
  parameter int DW    = $clog2(N_DIR)
) (
  input  logic [N_DIR-1:0] pending,
  input  logic [DW-1:0]    base,
  output logic [DW-1:0]    idx,
  output logic             found
);

  localparam int NR = N_DIR - 1;

  logic [NR-1:0] rot;
  int            pos;

  // rot[k] holds the request of approach base+1+k, so the lowest set bit is next in turn
  always_comb begin
    rot   = NR'({pending, pending} >> base >> 1);
    idx   = base;
    found = 1'b0;
    pos   = 0;
    for (int k = NR - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = int'(base) + k + 1;
        if (pos >= N_DIR) pos = pos - N_DIR;
        found = 1'b1;
        idx   = DW'(pos);
      end
    end
  end

endmodule

// File: rtl/traffic_controller_rr.sv
// N-approach intersection controller: round-robin green service with gap-out,
// emergency pre-emption and a flashing-yellow mode while disabled.
module traffic_controller_rr
  import traffic_pkg::*;
#(
  parameter int N_DIR     = 4,
  parameter int CW        = 8,
  parameter int GREEN_T   = 10,
  parameter int MIN_GREEN = 4,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int FLASH_T   = 8,
  parameter int DW        = $clog2(N_DIR)
) (
  input  logic               clk,
  input  logic               res,
  input  logic               en,
  input  logic [N_DIR-1:0]   req,
  input  logic               emg_valid,
  input  logic [DW-1:0]      emg_dir,
  output logic [3*N_DIR-1:0] lights,
  output logic [DW-1:0]      green_dir,
  output logic [2:0]         phase,
  output logic               emg_active
);

  localparam logic [CW-1:0] GREEN_LD  = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] YELLOW_LD = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALLRED_LD = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] FLASH_LD  = CW'(FLASH_T - 1);
  localparam logic [CW-1:0] MIN_LD    = CW'(MIN_GREEN - 1);

  phase_e           state;
  logic [CW-1:0]    timer;
  logic [CW-1:0]    elapsed;
  logic [N_DIR-1:0] pending;
  logic [DW-1:0]    target;
  logic             flash_on;

  logic [DW-1:0]    pick_idx;
  logic             pick_found;
  logic             emg_ok;
  logic             emg_here;
  logic             timer_zero;
  logic             gap_ok;

  function automatic logic [3*N_DIR-1:0] lamp(input logic [2:0] code, input logic [DW-1:0] dir);
    logic [3*N_DIR-1:0] v;
    for (int i = 0; i < N_DIR; i++) v[3*i +: 3] = (DW'(i) == dir) ? code : L_RED;
    return v;
  endfunction

  tl_rr_pick #(
    .N_DIR (N_DIR),
    .DW    (DW)
  ) u_pick (
    .pending (pending),
    .base    (green_dir),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  assign emg_ok     = emg_valid && (int'(emg_dir) < N_DIR);
  assign emg_here   = emg_ok && (emg_dir == green_dir);
  assign timer_zero = (timer == '0);
  // elapsed counts completed green cycles before this one, so MIN_LD means "this is cycle MIN_GREEN"
  assign gap_ok     = (elapsed >= MIN_LD) && !req[green_dir];
  assign phase      = state;

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= S_ALLRED;
      timer      <= ALLRED_LD;
      elapsed    <= '0;
      pending    <= '0;
      target     <= '0;
      green_dir  <= '0;
      flash_on   <= 1'b0;
      emg_active <= 1'b0;
      lights     <= {N_DIR{L_RED}};
    end else begin
      pending <= pending | req;
      if (!en) begin
        emg_active <= 1'b0;
        if (state != S_FLASH) begin
          state    <= S_FLASH;
          timer    <= FLASH_LD;
          flash_on <= 1'b1;
          lights   <= {N_DIR{L_YEL}};
        end else if (timer_zero) begin
          timer    <= FLASH_LD;
          flash_on <= ~flash_on;
          lights   <= {N_DIR{flash_code(~flash_on)}};
        end else begin
          timer <= timer - CW'(1);
        end
      end else begin
        case (state)
          S_FLASH: begin
            state  <= S_ALLRED;
            timer  <= ALLRED_LD;
            target <= green_dir;
            lights <= {N_DIR{L_RED}};
          end

          S_ALLRED: begin
            if (emg_ok) target <= emg_dir;
            if (!timer_zero) begin
              timer <= timer - CW'(1);
            end else if (emg_ok) begin
              state      <= S_EMG;
              green_dir  <= emg_dir;
              emg_active <= 1'b1;
              lights     <= lamp(L_GRN, emg_dir);
            end else begin
              // Serving an approach retires its request, even one arriving this very cycle
              state     <= S_GREEN;
              green_dir <= target;
              timer     <= GREEN_LD;
              elapsed   <= '0;
              pending   <= (pending | req) & ~(N_DIR'(1) << target);
              lights    <= lamp(L_GRN, target);
            end
          end

          S_GREEN: begin
            if (elapsed != {CW{1'b1}}) elapsed <= elapsed + CW'(1);
            if (emg_here) begin
              state      <= S_EMG;
              emg_active <= 1'b1;
            end else if (emg_ok || (pick_found && (timer_zero || gap_ok))) begin
              state  <= S_YELLOW;
              timer  <= YELLOW_LD;
              target <= emg_ok ? emg_dir : pick_idx;
              lights <= lamp(L_YEL, green_dir);
            end else if (timer_zero) begin
              timer <= GREEN_LD;
            end else begin
              timer <= timer - CW'(1);
            end
          end

          S_YELLOW: begin
            if (emg_ok) target <= emg_dir;
            if (timer_zero) begin
              state  <= S_ALLRED;
              timer  <= ALLRED_LD;
              lights <= {N_DIR{L_RED}};
            end else begin
              timer <= timer - CW'(1);
            end
          end

          S_EMG: begin
            // A redirected emergency leaves through yellow; the new direction is picked up there
            if (!emg_here) begin
              state      <= S_YELLOW;
              timer      <= YELLOW_LD;
              emg_active <= 1'b0;
              target     <= pick_found ? pick_idx : green_dir;
              lights     <= lamp(L_YEL, green_dir);
            end
          end

          default: begin
            state      <= S_ALLRED;
            timer      <= ALLRED_LD;
            emg_active <= 1'b0;
            lights     <= {N_DIR{L_RED}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_controller_rr.sv
// Directed bench for traffic_controller_rr with default parameters (4 approaches).
module tb_traffic_controller_rr;

  localparam logic [2:0] PH_ALLRED = 3'd0;
  localparam logic [2:0] PH_GREEN  = 3'd1;
  localparam logic [2:0] PH_YELLOW = 3'd2;
  localparam logic [2:0] PH_EMG    = 3'd3;
  localparam logic [2:0] PH_FLASH  = 3'd4;

  // Lamp words, approach 3 in the top three bits
  localparam logic [11:0] RED   = 12'h924;
  localparam logic [11:0] G0    = 12'h921;
  localparam logic [11:0] G1    = 12'h90C;
  localparam logic [11:0] G2    = 12'h864;
  localparam logic [11:0] G3    = 12'h324;
  localparam logic [11:0] Y0    = 12'h922;
  localparam logic [11:0] Y1    = 12'h914;
  localparam logic [11:0] Y3    = 12'h524;
  localparam logic [11:0] ALL_Y = 12'h492;
  localparam logic [11:0] DARK  = 12'h000;

  logic        clk = 1'b0;
  logic        res;
  logic        en;
  logic [3:0]  req;
  logic        emg_valid;
  logic [1:0]  emg_dir;
  logic [11:0] lights;
  logic [1:0]  green_dir;
  logic [2:0]  phase;
  logic        emg_active;

  int   vecs   = 0;
  int   errs   = 0;
  logic inv_en = 1'b0;

  always #5 clk = ~clk;

  traffic_controller_rr dut (
    .clk        (clk),
    .res        (res),
    .en         (en),
    .req        (req),
    .emg_valid  (emg_valid),
    .emg_dir    (emg_dir),
    .lights     (lights),
    .green_dir  (green_dir),
    .phase      (phase),
    .emg_active (emg_active)
  );

  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] rq,
                               input logic ev, input logic [1:0] ed);
    res       = r;
    en        = e;
    req       = rq;
    emg_valid = ev;
    emg_dir   = ed;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] exp_phase, input logic [1:0] exp_dir,
                             input logic [11:0] exp_lights, input logic exp_emg);
    vecs++;
    assert ({phase, green_dir, lights, emg_active} === {exp_phase, exp_dir, exp_lights, exp_emg})
    else begin
      errs++;
      $error("[TB] FAIL %s: got phase=%0d dir=%0d lights=%h emg=%b, want phase=%0d dir=%0d lights=%h emg=%b",
             tag, phase, green_dir, lights, emg_active, exp_phase, exp_dir, exp_lights, exp_emg);
    end
  endtask

  // Outside flashing mode no more than one approach may show green or yellow
  always @(negedge clk) begin : inv_chk
    int lit;
    if (inv_en && phase !== PH_FLASH) begin
      lit = 0;
      for (int i = 0; i < 4; i++)
        if (lights[3*i] === 1'b1 || lights[3*i+1] === 1'b1) lit++;
      vecs++;
      assert ((lit <= 1) === 1'b1)
      else begin
        errs++;
        $error("[TB] FAIL invariant: got %0d approaches lit, want at most 1", lit);
      end
    end
  end

  initial begin
    // Reset, then rest in green on approach 0
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 2'd0);
    tick(2);
    inv_en = 1'b1;
    checkOutput("reset", PH_ALLRED, 2'd0, RED, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
    tick(1); checkOutput("t1_red", PH_ALLRED, 2'd0, RED, 1'b0);
    tick(1); checkOutput("t1_green", PH_GREEN, 2'd0, G0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tick(1); checkOutput("t1_rest", PH_GREEN, 2'd0, G0, 1'b0);
    end

    // Gap-out after MIN_GREEN, then approach 2
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 2'd0); tick(1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0); tick(2);
    checkOutput("t2_g1", PH_GREEN, 2'd0, G0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0, 2'd0); tick(1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
    tick(2); checkOutput("t2_g4", PH_GREEN, 2'd0, G0, 1'b0);
    tick(1); checkOutput("t2_y1", PH_YELLOW, 2'd0, Y0, 1'b0);
    tick(2); checkOutput("t2_y3", PH_YELLOW, 2'd0, Y0, 1'b0);
    tick(1); checkOutput("t2_r1", PH_ALLRED, 2'd0, RED, 1'b0);
    tick(1); checkOutput("t2_r2", PH_ALLRED, 2'd0, RED, 1'b0);
    tick(1); checkOutput("t2_g_dir2", PH_GREEN, 2'd2, G2, 1'b0);

    // Held request keeps full green; service order 1 then 3
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 2'd0); tick(1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0); tick(2);
    applyStimulus(1'b0, 1'b1, 4'b1011, 1'b0, 2'd0); tick(1);
    applyStimulus(1'b0, 1'b1, 4'b0001, 1'b0, 2'd0);
    checkOutput("t3_g2", PH_GREEN, 2'd0, G0, 1'b0);
    tick(8); checkOutput("t3_g10", PH_GREEN, 2'd0, G0, 1'b0);
    tick(1); checkOutput("t3_y0", PH_YELLOW, 2'd0, Y0, 1'b0);
    tick(4); checkOutput("t3_r2", PH_ALLRED, 2'd0, RED, 1'b0);
    tick(1); checkOutput("t3_g_dir1", PH_GREEN, 2'd1, G1, 1'b0);
    tick(3); checkOutput("t3_g4_dir1", PH_GREEN, 2'd1, G1, 1'b0);
    tick(1); checkOutput("t3_y_dir1", PH_YELLOW, 2'd1, Y1, 1'b0);
    tick(4); checkOutput("t3_r2_dir1", PH_ALLRED, 2'd1, RED, 1'b0);
    tick(1); checkOutput("t3_g_dir3", PH_GREEN, 2'd3, G3, 1'b0);

    // Emergency to approach 3 while approach 1 is green
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 2'd0); tick(1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0); tick(2);
    applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0, 2'd0); tick(1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
    tick(2); checkOutput("t4_g4", PH_GREEN, 2'd0, G0, 1'b0);
    tick(5); checkOutput("t4_r2", PH_ALLRED, 2'd0, RED, 1'b0);
    tick(1); checkOutput("t4_g1_dir1", PH_GREEN, 2'd1, G1, 1'b0);
    tick(1); checkOutput("t4_g2_dir1", PH_GREEN, 2'd1, G1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1, 2'd3);
    tick(1); checkOutput("t4_y1", PH_YELLOW, 2'd1, Y1, 1'b0);
    tick(2); checkOutput("t4_y3", PH_YELLOW, 2'd1, Y1, 1'b0);
    tick(1); checkOutput("t4_r1", PH_ALLRED, 2'd1, RED, 1'b0);
    tick(1); checkOutput("t4_r2e", PH_ALLRED, 2'd1, RED, 1'b0);
    tick(1); checkOutput("t4_emg", PH_EMG, 2'd3, G3, 1'b1);
    for (int i = 0; i < 19; i++) begin
      tick(1); checkOutput("t4_emg_hold", PH_EMG, 2'd3, G3, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
    tick(1); checkOutput("t4_drop", PH_YELLOW, 2'd3, Y3, 1'b0);

    // Flashing yellow while disabled, then resume on the same approach
    tick(4); checkOutput("t5_r2", PH_ALLRED, 2'd3, RED, 1'b0);
    tick(1); checkOutput("t5_g_dir3", PH_GREEN, 2'd3, G3, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0);
    tick(1); checkOutput("t5_flash_on", PH_FLASH, 2'd3, ALL_Y, 1'b0);
    tick(7); checkOutput("t5_flash_on8", PH_FLASH, 2'd3, ALL_Y, 1'b0);
    tick(1); checkOutput("t5_flash_off", PH_FLASH, 2'd3, DARK, 1'b0);
    tick(7); checkOutput("t5_flash_off8", PH_FLASH, 2'd3, DARK, 1'b0);
    tick(1); checkOutput("t5_flash_on2", PH_FLASH, 2'd3, ALL_Y, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
    tick(1); checkOutput("t5_r1", PH_ALLRED, 2'd3, RED, 1'b0);
    tick(1); checkOutput("t5_r2b", PH_ALLRED, 2'd3, RED, 1'b0);
    tick(1); checkOutput("t5_resume", PH_GREEN, 2'd3, G3, 1'b0);

    // Reset in yellow with requests outstanding clears them
    applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0, 2'd0); tick(1);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
    tick(2); checkOutput("t6_g4", PH_GREEN, 2'd3, G3, 1'b0);
    tick(1); checkOutput("t6_y1", PH_YELLOW, 2'd3, Y3, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0, 2'd0);
    tick(1); checkOutput("t6_y2", PH_YELLOW, 2'd3, Y3, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 2'd0);
    tick(1); checkOutput("t6_reset", PH_ALLRED, 2'd0, RED, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
    tick(1); checkOutput("t6_red", PH_ALLRED, 2'd0, RED, 1'b0);
    tick(1); checkOutput("t6_g1", PH_GREEN, 2'd0, G0, 1'b0);
    tick(4); checkOutput("t6_g5", PH_GREEN, 2'd0, G0, 1'b0);
    tick(6); checkOutput("t6_g11", PH_GREEN, 2'd0, G0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
